// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA instruction loader.
// Holds the AXI / instruction geometry constants, the loader FSM state type,
// the instruction word type and the AR burst-length helper.
package cgra_pkg;

   localparam int C_M_AXI_ADDR_WIDTH = 64;
   localparam int phit_size          = 512;
   localparam int NUM_COL            = 2;
   localparam int INSTR_W            = 32;
   // Byte-offset bits inside one phit; forced to zero on the row-0 address.
   localparam int PHIT_LSB           = $clog2(phit_size / 8);

   typedef enum logic [1:0] {IDLE, AR, RDAT, DONE} ldr_state_t;

   typedef logic [INSTR_W-1:0] instr_t;

   // Beats in the next burst: whatever rows remain, capped at the burst limit.
   function automatic logic [31:0] burst_beats(input logic [31:0] rem,
                                               input logic [31:0] max_b);
      return (rem > max_b) ? max_b : rem;
   endfunction

endpackage

// File: rtl/cgra_instr_loader.sv
// Instruction-load sequencer for the CGRA kernel.
// On ctrl_start, reads up to IMEM_DEPTH rows (one phit per row) from m00,
// one AR burst outstanding at a time, and writes the low NUM_COL*INSTR_W bits
// of each beat into the per-column instruction memories. A one-cycle DONE
// state then pulses ctrl_done/exec_start and raises interrupt.
// Ports:
//   ap_clk, ap_rst_n           clock, synchronous active-low reset
//   ctrl_start/offset/size     load request from the control registers
//   ctrl_busy/done/err         status; err is sticky until the next start
//   interrupt                  level, set at done, cleared on next start
//   m00_axi_ar*/r*             AXI-MM read address / data channels
//   imem_we/waddr/wdata        registered column instruction-memory write
//   exec_start                 columns may begin fetching at row 0
module cgra_instr_loader
   import cgra_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int MAX_BURST  = 64
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst_n,
   input  logic                          ctrl_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_offset,
   input  logic [31:0]                   ctrl_size,
   output logic                          ctrl_busy,
   output logic                          ctrl_done,
   output logic                          ctrl_err,
   output logic                          interrupt,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
   output logic [7:0]                    m00_axi_arlen,
   output logic                          m00_axi_arvalid,
   input  logic                          m00_axi_arready,
   input  logic [phit_size-1:0]          m00_axi_rdata,
   input  logic                          m00_axi_rlast,
   input  logic                          m00_axi_rvalid,
   output logic                          m00_axi_rready,
   output logic [NUM_COL-1:0]            imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   output logic [NUM_COL*INSTR_W-1:0]    imem_wdata,
   output logic                          exec_start
);

   localparam int AW = $clog2(IMEM_DEPTH);     // row address width
   localparam int CW = $clog2(IMEM_DEPTH + 1); // row count width (holds IMEM_DEPTH)

   ldr_state_t                    state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] offset_q, offset_d;
   logic [CW-1:0]                 n_q, n_d;           // rows to load
   logic [CW-1:0]                 issued_q, issued_d; // rows covered by issued ARs
   logic [CW-1:0]                 beats_q, beats_d;   // beats left in current burst
   logic [AW-1:0]                 row_q, row_d;       // imem row of the next beat
   logic                          we_q, we_d;
   logic [AW-1:0]                 waddr_q, waddr_d;
   instr_t [NUM_COL-1:0]          wdata_q, wdata_d;
   logic                          err_q, err_d;
   logic                          intr_q, intr_d;

   logic [31:0] blen;
   logic        beat, last_exp, burst_end;

   assign blen      = burst_beats(32'(n_q - issued_q), 32'(MAX_BURST));
   assign beat      = m00_axi_rvalid && (state_q == RDAT);
   assign last_exp  = (beats_q == CW'(1));
   // A burst ends on rlast or on its expected last beat, whichever comes first.
   assign burst_end = beat && (m00_axi_rlast || last_exp);

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      n_d      = n_q;
      issued_d = issued_q;
      beats_d  = beats_q;
      row_d    = row_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      intr_d   = intr_q;
      case (state_q)
         IDLE: begin
            if (ctrl_start) begin
               offset_d = {ctrl_offset[C_M_AXI_ADDR_WIDTH-1:PHIT_LSB], {PHIT_LSB{1'b0}}};
               if (ctrl_size > 32'(IMEM_DEPTH)) begin
                  n_d   = CW'(IMEM_DEPTH);
                  err_d = 1'b1;
               end else begin
                  n_d   = ctrl_size[CW-1:0];
                  err_d = 1'b0;
               end
               intr_d   = 1'b0;
               issued_d = '0;
               row_d    = '0;
               state_d  = (n_d == '0) ? DONE : AR;
            end
         end
         AR: begin
            if (m00_axi_arready) begin
               // Re-align the row counter to this burst's first row, in case
               // an earlier burst ended short.
               row_d    = issued_q[AW-1:0];
               issued_d = issued_q + CW'(blen);
               beats_d  = CW'(blen);
               state_d  = RDAT;
            end
         end
         RDAT: begin
            if (beat) begin
               we_d    = 1'b1;
               waddr_d = row_q;
               wdata_d = m00_axi_rdata[NUM_COL*INSTR_W-1:0];
               if (32'(row_q) + 32'd1 < 32'(n_q)) row_d = row_q + AW'(1);
               beats_d = beats_q - CW'(1);
               if (m00_axi_rlast != last_exp) err_d = 1'b1;
               if (burst_end) state_d = (issued_q == n_q) ? DONE : AR;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == DONE) intr_d = 1'b1;
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q  <= IDLE;
         offset_q <= '0;
         n_q      <= '0;
         issued_q <= '0;
         beats_q  <= '0;
         row_q    <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         intr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         n_q      <= n_d;
         issued_q <= issued_d;
         beats_q  <= beats_d;
         row_q    <= row_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         intr_q   <= intr_d;
      end
   end

   assign m00_axi_arvalid = (state_q == AR);
   assign m00_axi_araddr  = m00_axi_arvalid ?
                            offset_q + (C_M_AXI_ADDR_WIDTH'(issued_q) << PHIT_LSB) : '0;
   assign m00_axi_arlen   = m00_axi_arvalid ? 8'(blen - 32'd1) : 8'd0;
   assign m00_axi_rready  = (state_q == RDAT);

   assign imem_we    = {NUM_COL{we_q}};
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;

   // The final registered write is presented in the DONE cycle, so the memory
   // commits it on the same edge at which the columns see exec_start.
   assign ctrl_busy  = (state_q != IDLE);
   assign ctrl_done  = (state_q == DONE);
   assign exec_start = (state_q == DONE);
   assign ctrl_err   = err_q;
   assign interrupt  = intr_q;

   logic unused_bits;
   assign unused_bits = ^{m00_axi_rdata[phit_size-1:NUM_COL*INSTR_W],
                          ctrl_offset[PHIT_LSB-1:0]};

endmodule
